pin_keypad_tx: RTL

// - Keypad-side transmitter for the parking gate controller's PIN interface.
// - Collects BCD digit keystrokes and packs them into Pin.
// - On an ENTER key, emits one registered enterPin strobe with Pin held stable.
// - Sits between the keypad scanner and the gate controller's Pin/enterPin inputs.

---
 rtl/pin_keypad_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pin_keypad_tx.sv
// Keypad-side PIN transmitter: packs BCD keystrokes and strobes enterPin on ENTER.
// Optional inter-key timeout is built when PIN_TIMEOUT_EN is defined.
module pin_keypad_tx #(
  parameter int DIGITS      = 2,
  parameter int HOLD_CYC    = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         KeyValid,
  input  logic [3:0]                   KeyCode,
  output logic [4*DIGITS-1:0]          Pin,
  output logic                         enterPin,
  output logic                         Busy,
  output logic [$clog2(DIGITS+1)-1:0]  DigitCnt,
  output logic                         KeyErr
);

  localparam int PW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);

  typedef enum logic [1:0] {IDLE, COLLECT, SEND, HOLD} state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   shift_reg, shift_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [HW-1:0]   hold_reg, hold_next;
  logic [PW-1:0]   pin_reg, pin_next;
  logic            enter_reg, enter_next;
  logic            busy_reg, busy_next;
  logic            err_reg, err_next;
  logic            timeout_hit;

  logic            is_digit, is_enter, is_clear, is_key;
  logic [PW-1:0]   shifted;

  assign is_digit = KeyValid && (KeyCode <= 4'd9);
  assign is_enter = KeyValid && (KeyCode == 4'hA);
  assign is_clear = KeyValid && (KeyCode == 4'hB);
  assign is_key   = is_digit || is_enter || is_clear;
  assign shifted  = (shift_reg << 4) | PW'(KeyCode);

`ifdef PIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] to_reg, to_next;

  assign timeout_hit = (state_reg == COLLECT) && (to_reg == TW'(TIMEOUT_CYC - 1)) && !is_key;

  // Counter only advances while idling in COLLECT; any real key restarts it.
  always_comb begin
    to_next = '0;
    if (state_next == COLLECT && state_reg == COLLECT && !is_key)
      to_next = to_reg + TW'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) to_reg <= '0;
    else       to_reg <= to_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      cnt_reg   <= '0;
      hold_reg  <= '0;
      pin_reg   <= '0;
      enter_reg <= 1'b0;
      busy_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= hold_next;
      pin_reg   <= pin_next;
      enter_reg <= enter_next;
      busy_reg  <= busy_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    cnt_next   = cnt_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (is_digit) begin
          state_next = COLLECT;
          shift_next = shifted;
          cnt_next   = CW'(1);
        end
      end
      COLLECT: begin
        if (is_clear || (is_enter && cnt_reg != FULL_CNT) || timeout_hit) begin
          state_next = IDLE;
          shift_next = '0;
          cnt_next   = '0;
        end else if (is_enter) begin
          state_next = SEND;
        end else if (is_digit && cnt_reg < FULL_CNT) begin
          shift_next = shifted;
          cnt_next   = cnt_reg + CW'(1);
        end
      end
      SEND: begin
        state_next = HOLD;
        hold_next  = HW'(HOLD_CYC);
      end
      HOLD: begin
        if (hold_reg <= HW'(1)) begin
          state_next = IDLE;
          hold_next  = '0;
          shift_next = '0;
          cnt_next   = '0;
        end else begin
          hold_next = hold_reg - HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values for the registered outputs, keyed on the state being entered.
  always_comb begin
    pin_next   = '0;
    enter_next = 1'b0;
    busy_next  = 1'b0;
    case (state_next)
      SEND: begin
        pin_next   = shift_reg;
        enter_next = 1'b1;
        busy_next  = 1'b1;
      end
      HOLD: begin
        pin_next  = pin_reg;
        busy_next = 1'b1;
      end
      default: ;
    endcase
    err_next = (state_reg == COLLECT) && (state_next == IDLE) && !is_clear;
  end

  assign Pin      = pin_reg;
  assign enterPin = enter_reg;
  assign Busy     = busy_reg;
  assign DigitCnt = cnt_reg;
  assign KeyErr   = err_reg;

endmodule
